// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: tick prescaler, run/pause/lap/full sequencing,
// BCD counter enable/clear generation and lap-freeze display selection.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV    = 100_000_000,
   parameter bit          STOP_AT_MAX = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic [3:0] disp_ones,
   output logic [3:0] disp_tens,
   output logic [2:0] state,
   output logic       running,
   output logic       full,
   output logic       wrap
);

   localparam int unsigned     PrescW   = $clog2(TICK_DIV);
   localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StLap   = 3'd2,
      StPause = 3'd3,
      StFull  = 3'd4
   } state_e;

   state_e            state_q;
   logic [PrescW-1:0] presc_q;
   logic [7:0]        lap_q;      // {tens, ones} captured at lap
   logic              cnt_clr_q;
   logic              wrap_q;

   logic active;
   logic tick;
   logic at_max;
   logic halt;

   // Tick decode and counter enable; enable depends on the current state only.
   always_comb begin
      active = (state_q == StRun) || (state_q == StLap);
      tick   = (presc_q == PrescMax);
      at_max = (tens == 4'd9) && (ones == 4'd9);
      halt   = STOP_AT_MAX && at_max;
      cnt_en = tick && active && !clear && !halt;
   end

   // Control FSM with prescaler, lap latch and registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         lap_q     <= '0;
         cnt_clr_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         cnt_clr_q <= clear;
         // cnt_en is already forced low at 99 when halting, so this only fires on a rollover
         wrap_q    <= cnt_en && at_max;
         if (clear) begin
            state_q <= StIdle;
            presc_q <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  presc_q <= '0;
                  if (start_stop) state_q <= StRun;
               end
               StRun, StLap: begin
                  presc_q <= tick ? '0 : presc_q + 1'b1;
                  if (tick && halt) begin
                     state_q <= StFull;
                     presc_q <= '0;
                  end else if (start_stop) begin
                     state_q <= StPause;
                  end else if (lap) begin
                     if (state_q == StRun) begin
                        state_q <= StLap;
                        lap_q   <= {tens, ones};
                     end else begin
                        state_q <= StRun;
                     end
                  end
               end
               // Prescaler holds so the residual count survives the pause
               StPause: begin
                  if (start_stop) state_q <= StRun;
               end
               StFull: begin
                  presc_q <= '0;
               end
               default: begin
                  state_q <= StIdle;
                  presc_q <= '0;
               end
            endcase
         end
      end
   end

   // Display mux: frozen lap value in LAP, live digits otherwise.
   always_comb begin
      if (state_q == StLap) begin
         disp_tens = lap_q[7:4];
         disp_ones = lap_q[3:0];
      end else begin
         disp_tens = tens;
         disp_ones = ones;
      end
   end

   assign state   = state_q;
   assign running = active;
   assign full    = (state_q == StFull);
   assign cnt_clr = cnt_clr_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: two DUTs (halt-at-99 and wrap) share random button
// stimulus; a behavioural model predicts every cycle's outputs.
module tb_stopwatch_ctrl;

   localparam int Tick   = 4;
   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MLap   = 2;
   localparam int MPause = 3;
   localparam int MFull  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_stop = 1'b0;
   logic lap = 1'b0;
   logic clear = 1'b0;

   // Halting DUT (STOP_AT_MAX=1)
   logic [3:0] ones_h, tens_h, dones_h, dtens_h;
   logic [2:0] state_h;
   logic       cnt_en_h, cnt_clr_h, running_h, full_h, wrap_h;
   int         cnt_h = 0;
   // Wrapping DUT (STOP_AT_MAX=0)
   logic [3:0] ones_w, tens_w, dones_w, dtens_w;
   logic [2:0] state_w;
   logic       cnt_en_w, cnt_clr_w, running_w, full_w, wrap_w;
   int         cnt_w = 0;

   int n_cmp  = 0;
   int n_fail = 0;
   int cycle  = 0;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(Tick), .STOP_AT_MAX(1'b1)) u_dut_h (
      .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
      .ones(ones_h), .tens(tens_h), .cnt_en(cnt_en_h), .cnt_clr(cnt_clr_h),
      .disp_ones(dones_h), .disp_tens(dtens_h), .state(state_h),
      .running(running_h), .full(full_h), .wrap(wrap_h)
   );

   stopwatch_ctrl #(.TICK_DIV(Tick), .STOP_AT_MAX(1'b0)) u_dut_w (
      .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
      .ones(ones_w), .tens(tens_w), .cnt_en(cnt_en_w), .cnt_clr(cnt_clr_w),
      .disp_ones(dones_w), .disp_tens(dtens_w), .state(state_w),
      .running(running_w), .full(full_w), .wrap(wrap_w)
   );

   // Environment: the BCD counters the controller drives
   always @(posedge clk) begin
      if (rst || cnt_clr_h) cnt_h <= 0;
      else if (cnt_en_h)    cnt_h <= (cnt_h + 1) % 100;
      if (rst || cnt_clr_w) cnt_w <= 0;
      else if (cnt_en_w)    cnt_w <= (cnt_w + 1) % 100;
   end
   assign ones_h = 4'(cnt_h % 10);
   assign tens_h = 4'(cnt_h / 10);
   assign ones_w = 4'(cnt_w % 10);
   assign tens_w = 4'(cnt_w / 10);

   typedef struct {
      int mode;      // stopwatch mode in spec encoding
      int elapsed;   // cycles counted toward the next tick
      int frozen;    // lap snapshot as a 0..99 number
      bit clr_p;     // clear pulse owed next cycle
      bit wrap_p;    // wrap pulse owed next cycle
      int count;     // what the counter reads
   } mdl_t;

   typedef struct {
      bit cnt_en;
      bit cnt_clr;
      bit wrap;
      bit full;
      bit running;
      int state;
      int disp;
      int count;
   } exp_t;

   exp_t q_h[$];
   exp_t q_w[$];
   mdl_t m_h, m_w;

   function automatic mdl_t reset_model();
      mdl_t r;
      r.mode = MIdle; r.elapsed = 0; r.frozen = 0;
      r.clr_p = 1'b0; r.wrap_p = 1'b0; r.count = 0;
      return r;
   endfunction

   function automatic bit chance(int n);
      return ($urandom_range(n - 1, 0) == 0);
   endfunction

   // One cycle of stopwatch behaviour: outputs now, state after the edge
   function automatic void model_step(input mdl_t s, input bit stop, input bit ss,
                                      input bit lp, input bit cl,
                                      output exp_t e, output mdl_t n);
      bit act, tk, hlt;
      act = (s.mode == MRun) || (s.mode == MLap);
      tk  = act && (s.elapsed == Tick - 1);
      hlt = stop && (s.count == 99);
      e.cnt_en  = tk && !cl && !hlt;
      e.cnt_clr = s.clr_p;
      e.wrap    = s.wrap_p;
      e.full    = (s.mode == MFull);
      e.running = act;
      e.state   = s.mode;
      e.disp    = (s.mode == MLap) ? s.frozen : s.count;
      e.count   = s.count;
      n = s;
      n.clr_p  = cl;
      n.wrap_p = e.cnt_en && (s.count == 99);
      if (s.clr_p)        n.count = 0;
      else if (e.cnt_en)  n.count = (s.count + 1) % 100;
      if (act)                  n.elapsed = tk ? 0 : s.elapsed + 1;
      else if (s.mode != MPause) n.elapsed = 0;
      if (cl) begin
         n.mode = MIdle;
         n.elapsed = 0;
      end else if (s.mode == MIdle) begin
         if (ss) n.mode = MRun;
      end else if (act) begin
         if (tk && hlt) begin
            n.mode = MFull;
            n.elapsed = 0;
         end else if (ss) begin
            n.mode = MPause;
         end else if (lp) begin
            if (s.mode == MRun) begin
               n.mode = MLap;
               n.frozen = s.count;
            end else begin
               n.mode = MRun;
            end
         end
      end else if (s.mode == MPause) begin
         if (ss) n.mode = MRun;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
      end
   endtask

   // Monitor: pops one expectation per DUT per cycle and compares
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (q_h.size() != 0) begin
            e = q_h.pop_front();
            check("h.cnt_en",    32'(cnt_en_h),  32'(e.cnt_en));
            check("h.cnt_clr",   32'(cnt_clr_h), 32'(e.cnt_clr));
            check("h.wrap",      32'(wrap_h),    32'(e.wrap));
            check("h.full",      32'(full_h),    32'(e.full));
            check("h.running",   32'(running_h), 32'(e.running));
            check("h.state",     32'(state_h),   32'(e.state));
            check("h.disp_ones", 32'(dones_h),   32'(e.disp % 10));
            check("h.disp_tens", 32'(dtens_h),   32'(e.disp / 10));
            check("h.count",     32'(cnt_h),     32'(e.count));
         end
         if (q_w.size() != 0) begin
            e = q_w.pop_front();
            check("w.cnt_en",    32'(cnt_en_w),  32'(e.cnt_en));
            check("w.cnt_clr",   32'(cnt_clr_w), 32'(e.cnt_clr));
            check("w.wrap",      32'(wrap_w),    32'(e.wrap));
            check("w.full",      32'(full_w),    32'(e.full));
            check("w.running",   32'(running_w), 32'(e.running));
            check("w.state",     32'(state_w),   32'(e.state));
            check("w.disp_ones", 32'(dones_w),   32'(e.disp % 10));
            check("w.disp_tens", 32'(dtens_w),   32'(e.disp / 10));
            check("w.count",     32'(cnt_w),     32'(e.count));
         end
      end
   end

   // Driver: random button pulses in phases of differing density
   initial begin
      exp_t e;
      mdl_t nx;
      bit   r, ss, lp, cl;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      m_h = reset_model();
      m_w = reset_model();
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         cycle = i;
         if (i < 3000 || i >= 9000) begin
            // long runs without clear so the count reaches 99
            r = 1'b0; cl = 1'b0; ss = chance(300); lp = chance(100);
         end else if (i < 6000) begin
            // dense: frequent coincident pulses
            r = chance(200); cl = chance(4); ss = chance(4); lp = chance(4);
         end else begin
            r = chance(3000); cl = chance(600); ss = chance(50); lp = chance(40);
         end
         rst = r; start_stop = ss; lap = lp; clear = cl;
         model_step(m_h, 1'b1, ss, lp, cl, e, nx);
         q_h.push_back(e);
         m_h = r ? reset_model() : nx;
         model_step(m_w, 1'b0, ss, lp, cl, e, nx);
         q_w.push_back(e);
         m_w = r ? reset_model() : nx;
      end
      @(negedge clk);
      rst = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
      #2;
      check("queue_drained", 32'(q_h.size() + q_w.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch. It sequences the two-digit BCD counter (00–99) by generating that counter's enable and clear. It divides the system clock into count ticks and decodes single-cycle start/stop, lap and clear pulses. It also drives the display digits, either live or frozen at a lap capture. It sits between the debounced button logic and the BCD counter / 7-segment display path.

## Interface
- TICK_DIV, default 100_000_000: clk cycles per count tick. Must be ≥ 2. The prescaler width is $clog2(TICK_DIV).
- STOP_AT_MAX, default 1: 1 = halt in FULL at 99; 0 = let the counter wrap 99→00.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_stop  in  1  single-cycle pulse; toggles run/pause
- lap  in  1  single-cycle pulse; capture/release of the lap display
- clear  in  1  single-cycle pulse; return to 00
- ones  in  4  live BCD ones digit from the counter
- tens  in  4  live BCD tens digit from the counter
- cnt_en  out  1  counter enable; one-cycle pulse per tick
- cnt_clr  out  1  counter clear; registered one-cycle pulse
- disp_ones  out  4  displayed ones digit
- disp_tens  out  4  displayed tens digit
- state  out  3  FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3, FULL=4
- running  out  1  high in RUN or LAP
- full  out  1  high in FULL
- wrap  out  1  registered one-cycle pulse on 99→00 rollover (STOP_AT_MAX=0 only)

## Operation
- Reset values:
  - state=IDLE, prescaler=0, lap latch=00.
  - cnt_clr=0, wrap=0, full=0, running=0, cnt_en=0.
  - disp_* = live ones/tens.
- Prescaler behaviour:
  - RUN or LAP: increments every cycle. tick = (presc==TICK_DIV-1); on tick the prescaler returns to 0.
  - PAUSE: holds its value, so the residual is kept and resume is exact.
  - IDLE and FULL: forced to 0.
- cnt_en is combinational: cnt_en = tick && state∈{RUN,LAP} && !clear && !halt.
  - halt = (STOP_AT_MAX && tens==9 && ones==9).
- Transitions (priority order within a cycle: clear > max-halt > start_stop > lap):
  - Any state, on clear: → IDLE. cnt_clr=1 in the next cycle; prescaler=0.
  - IDLE, on start_stop: → RUN. lap is ignored.
  - RUN:
    - tick && halt: → FULL, and cnt_en is suppressed.
    - start_stop: → PAUSE.
    - lap: → LAP; latch {tens,ones} in the same cycle.
  - LAP:
    - tick && halt: → FULL.
    - start_stop: → PAUSE.
    - lap: → RUN, releasing the freeze.
  - PAUSE: start_stop → RUN. lap is ignored.
  - FULL: only clear has an effect; start_stop and lap are ignored.
- Display:
  - disp_* = lap latch in LAP; live ones/tens in every other state.
- Wrap (STOP_AT_MAX=0): a tick at 99 asserts cnt_en normally. wrap is high in the cycle after that tick, when the counter reads 00.
- A tick coinciding with start_stop in RUN still counts, because cnt_en depends on the current state.
- start_stop+lap in the same cycle in RUN: → PAUSE. No lap capture occurs.

## Timing
- Inputs are sampled at the posedge. State changes at the same edge.
- After a start_stop pulse from IDLE, the first cnt_en is high during the TICK_DIV-th cycle spent in RUN. Later cnt_en pulses follow every TICK_DIV cycles.
- The counter value updates at the edge that ends the cnt_en cycle, so the display lags cnt_en by 1 cycle.
- clear sampled at edge N:
  - state=IDLE after N.
  - cnt_clr high during cycle N+1.
  - counter reads 00 after edge N+1.
  - disp may show the stale value for those 2 cycles.
- Lap capture: the latched value equals ones/tens as seen at the capture edge. disp freezes from the next cycle.
- rst mid-operation: all outputs return to their reset values at the next edge. In-progress prescaler and lap latch contents are discarded.

## Test plan
- TICK_DIV=4, run from IDLE → cnt_en first high on the 4th RUN cycle, then every 4 cycles; after 40 RUN cycles the counter reads 10.
- Pause with the prescaler at 2 → no cnt_en for 20 cycles; after resume the next cnt_en comes 1 cycle later (presc reaches 3).
- Lap at count 12 → disp holds 12 while the counter reaches 20; a second lap gives disp=20 the next cycle and state=RUN.
- STOP_AT_MAX=1, run to 99 → the next tick gives cnt_en=0, state=FULL, full=1, counter stays 99. start_stop is ignored. clear → IDLE, one cnt_clr pulse, counter 00.
- STOP_AT_MAX=0, tick at 99 → cnt_en=1, counter 00, wrap high for exactly 1 cycle, state remains RUN.
- Simultaneous events:
  - clear+start_stop in RUN → IDLE, and cnt_en is suppressed on a coinciding tick.
  - start_stop+lap in RUN → PAUSE with the lap latch unchanged.
  - rst in LAP → state=0, disp live, all flags 0.
